ecg_window_feeder: RTL and testbench



---
 rtl/ecg_window_feeder.sv | 154 +++++++++++++++
 tb/tb_ecg_window_feeder.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ecg_window_feeder.sv
// rtl/ecg_window_feeder.sv - 5-sample sliding window feeder for an ECG layer node
// Presents each new window on A0x..A4x and captures the node result NODE_LAT cycles later.
module ecg_window_feeder #(
  parameter int STRIDE   = 1,
  parameter int NODE_LAT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [7:0]  A0x,
  output logic [7:0]  A1x,
  output logic [7:0]  A2x,
  output logic [7:0]  A3x,
  output logic [7:0]  A4x,
  output logic        win_valid,
  input  logic [7:0]  N8x_in,
  output logic [7:0]  res_data,
  output logic        res_valid,
  output logic [15:0] res_count
);

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam logic [4:0] STRIDE_W = 5'(STRIDE);

  state_t              state_q, state_d;
  logic [2:0]          fill_cnt_q, fill_cnt_d;
  logic [3:0]          stride_cnt_q, stride_cnt_d;
  logic [4:0][7:0]     win_q, win_d;
  logic                win_valid_q, win_valid_d;
  logic [NODE_LAT-1:0] pipe_q, pipe_d;
  logic [7:0]          res_data_q, res_data_d;
  logic                res_valid_q, res_valid_d;
  logic [15:0]         res_count_q, res_count_d;
  logic                accept;
  logic                capture;

  assign s_ready = !reset && !flush && (state_q != ST_FLUSH);
  assign accept  = s_valid && s_ready;
  assign capture = pipe_q[NODE_LAT-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_FLUSH;
    end else begin
      case (state_q)
        ST_FILL:  if (accept && fill_cnt_q == 3'd4) state_d = ST_RUN;
        ST_RUN:   state_d = ST_RUN;
        ST_FLUSH: state_d = ST_FILL;
        default:  state_d = ST_FILL;
      endcase
    end
  end

  always_comb begin
    fill_cnt_d   = fill_cnt_q;
    stride_cnt_d = stride_cnt_q;
    win_d        = win_q;
    win_valid_d  = 1'b0;
    pipe_d       = pipe_q << 1;
    pipe_d[0]    = win_valid_q;
    res_valid_d  = capture;
    res_data_d   = capture ? N8x_in : res_data_q;
    res_count_d  = capture ? res_count_q + 16'd1 : res_count_q;

    // win_q[0] is the oldest sample, win_q[4] the newest
    if (accept) begin
      win_d = {s_data, win_q[4:1]};
    end

    case (state_q)
      ST_FILL: begin
        if (accept) begin
          fill_cnt_d = fill_cnt_q + 3'd1;
          if (fill_cnt_q == 3'd4) begin
            win_valid_d  = 1'b1;
            stride_cnt_d = 4'd0;
          end
        end
      end
      ST_RUN: begin
        if (accept) begin
          if ({1'b0, stride_cnt_q} + 5'd1 == STRIDE_W) begin
            win_valid_d  = 1'b1;
            stride_cnt_d = 4'd0;
          end else begin
            stride_cnt_d = stride_cnt_q + 4'd1;
          end
        end
      end
      default: ;
    endcase

    // A flush drops every window in flight, including one due for capture now
    if (flush) begin
      fill_cnt_d   = 3'd0;
      stride_cnt_d = 4'd0;
      win_valid_d  = 1'b0;
      pipe_d       = '0;
      res_valid_d  = 1'b0;
      res_data_d   = res_data_q;
      res_count_d  = res_count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fill_cnt_q   <= 3'd0;
      stride_cnt_q <= 4'd0;
      win_q        <= '0;
      win_valid_q  <= 1'b0;
      pipe_q       <= '0;
      res_data_q   <= 8'd0;
      res_valid_q  <= 1'b0;
      res_count_q  <= 16'd0;
    end else begin
      fill_cnt_q   <= fill_cnt_d;
      stride_cnt_q <= stride_cnt_d;
      win_q        <= win_d;
      win_valid_q  <= win_valid_d;
      pipe_q       <= pipe_d;
      res_data_q   <= res_data_d;
      res_valid_q  <= res_valid_d;
      res_count_q  <= res_count_d;
    end
  end

  assign A0x       = win_q[0];
  assign A1x       = win_q[1];
  assign A2x       = win_q[2];
  assign A3x       = win_q[3];
  assign A4x       = win_q[4];
  assign win_valid = win_valid_q;
  assign res_data  = res_data_q;
  assign res_valid = res_valid_q;
  assign res_count = res_count_q;

endmodule

// File: tb/tb_ecg_window_feeder.sv
// tb/tb_ecg_window_feeder.sv - randomized bench for ecg_window_feeder against a window/event model
// Two instances (STRIDE 1 / NODE_LAT 3 and STRIDE 3 / NODE_LAT 5) share the sample stream.
module tb_ecg_window_feeder;

  logic        clk;
  logic        reset;
  logic        flush;
  logic [7:0]  s_data;
  logic        s_valid;
  logic [7:0]  n8 [2];
  logic        sr [2];
  logic [7:0]  a0 [5];
  logic [7:0]  a1 [5];
  logic        wv [2];
  logic [7:0]  rd [2];
  logic        rv [2];
  logic [15:0] rc [2];

  int checks = 0;
  int errors = 0;

  int          stride_p [2] = '{1, 3};
  int          lat_p [2]    = '{3, 5};
  int          cyc = 0;
  logic [7:0]  hist [5];
  int          m_n;
  bit          m_fl;
  logic [15:0] m_cnt [2];
  logic [7:0]  m_rd [2];
  logic [7:0]  node_s [int];
  logic [7:0]  res_s [int];

  ecg_window_feeder #(.STRIDE(1), .NODE_LAT(3)) dut0 (
    .clk(clk), .reset(reset), .flush(flush), .s_data(s_data), .s_valid(s_valid),
    .s_ready(sr[0]), .A0x(a0[0]), .A1x(a0[1]), .A2x(a0[2]), .A3x(a0[3]), .A4x(a0[4]),
    .win_valid(wv[0]), .N8x_in(n8[0]), .res_data(rd[0]), .res_valid(rv[0]), .res_count(rc[0])
  );

  ecg_window_feeder #(.STRIDE(3), .NODE_LAT(5)) dut1 (
    .clk(clk), .reset(reset), .flush(flush), .s_data(s_data), .s_valid(s_valid),
    .s_ready(sr[1]), .A0x(a1[0]), .A1x(a1[1]), .A2x(a1[2]), .A3x(a1[3]), .A4x(a1[4]),
    .win_valid(wv[1]), .N8x_in(n8[1]), .res_data(rd[1]), .res_valid(rv[1]), .res_count(rc[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h expected %0h", tag, cyc, act, exp);
    end
  endtask

  // Arbitrary node transfer function of the presented window
  function automatic logic [7:0] node_f(input int i);
    logic [7:0] s;
    s = hist[0] + 8'd3 * hist[1] + 8'd5 * hist[2] + 8'd7 * hist[3] + 8'd11 * hist[4];
    return (i == 0) ? s : (s ^ 8'h5A);
  endfunction

  task automatic step(input bit r, input bit f, input bit v, input logic [7:0] d);
    int  e;
    int  key;
    bit  acc;
    bit  exp_rdy;
    bit  win [2];
    bit  rvx [2];
    logic [7:0] nv;
    reset   = r;
    flush   = f;
    s_valid = v;
    s_data  = d;
    for (int i = 0; i < 2; i++) begin
      key   = cyc * 2 + i;
      n8[i] = node_s.exists(key) ? node_s[key] : 8'($urandom);
    end
    #1;
    exp_rdy = !r && !f && !m_fl;
    check("s_ready0", 32'(sr[0]), 32'(exp_rdy));
    check("s_ready1", 32'(sr[1]), 32'(exp_rdy));
    e   = cyc + 1;
    acc = v && exp_rdy;
    win = '{0, 0};
    rvx = '{0, 0};
    if (r) begin
      for (int j = 0; j < 5; j++) hist[j] = 8'd0;
      m_n  = 0;
      m_fl = 0;
      res_s.delete();
      m_cnt = '{16'd0, 16'd0};
      m_rd  = '{8'd0, 8'd0};
    end else begin
      for (int i = 0; i < 2; i++) begin
        key    = e * 2 + i;
        rvx[i] = !f && res_s.exists(key);
        if (rvx[i]) begin
          m_rd[i]  = res_s[key];
          m_cnt[i] = m_cnt[i] + 16'd1;
        end
        if (res_s.exists(key)) res_s.delete(key);
      end
      if (f) begin
        res_s.delete();
        m_n  = 0;
        m_fl = 1;
      end else begin
        m_fl = 0;
        if (acc) begin
          for (int j = 0; j < 4; j++) hist[j] = hist[j+1];
          hist[4] = d;
          m_n++;
          for (int i = 0; i < 2; i++) begin
            if (m_n == 5 || (m_n > 5 && (m_n - 5) % stride_p[i] == 0)) begin
              win[i] = 1;
              nv = node_f(i);
              node_s[(e + lat_p[i]) * 2 + i]     = nv;
              res_s[(e + lat_p[i] + 1) * 2 + i]  = nv;
            end
          end
        end
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    for (int j = 0; j < 5; j++) begin
      check("A_inst0", 32'(a0[j]), 32'(hist[j]));
      check("A_inst1", 32'(a1[j]), 32'(hist[j]));
    end
    for (int i = 0; i < 2; i++) begin
      check("win_valid", 32'(wv[i]), 32'(win[i]));
      check("res_valid", 32'(rv[i]), 32'(rvx[i]));
      check("res_data", 32'(rd[i]), 32'(m_rd[i]));
      check("res_count", 32'(rc[i]), 32'(m_cnt[i]));
    end
  endtask

  initial begin
    bit seen;
    reset = 1'b1; flush = 1'b0; s_valid = 1'b0; s_data = 8'd0;
    n8[0] = 8'd0; n8[1] = 8'd0;
    m_n = 0; m_fl = 0;

    step(1, 0, 0, 8'd0);
    step(1, 0, 0, 8'd0);
    for (int k = 1; k <= 7; k++) step(0, 0, 1, 8'(k * 10));
    for (int k = 0; k < 8; k++) step(0, 0, 0, 8'd0);

    // sample 99 arrives together with flush while results are in flight
    for (int k = 1; k <= 8; k++) step(0, 0, 1, 8'(k));
    step(0, 1, 1, 8'd99);
    for (int k = 1; k <= 5; k++) step(0, 0, 1, 8'(k));
    for (int k = 0; k < 8; k++) step(0, 0, 0, 8'd0);

    // reset mid-run with a window pending
    for (int k = 0; k < 7; k++) step(0, 0, 1, 8'($urandom));
    step(1, 0, 1, 8'h55);
    for (int k = 0; k < 10; k++) step(0, 0, (k > 3), 8'($urandom));

    for (int k = 0; k < 2000; k++) begin
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 3) != 0), 8'($urandom));
    end

    // res_count wrap
    for (int k = 0; k < 6; k++) step(0, 0, 1, 8'($urandom));
    for (int k = 0; k < 8; k++) step(0, 0, 0, 8'd0);
    force dut0.res_count_q = 16'hFFFF;
    m_cnt[0] = 16'hFFFF;
    #1;
    release dut0.res_count_q;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step(0, 0, 1, 8'($urandom));
      seen = rv[0];
    end
    if (seen) check("wrap", 32'(rc[0]), 32'h0);
    else check("wrap_timeout", 32'(seen), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
